// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// master: requester/memory side; slave: arbiter side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  ack0, ack1, rdata0, rdata1,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    input  busy
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output ack0, ack1, rdata0, rdata1,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    output busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory port between two requesters.
// Ports: clk, rst (async active-low), bus (dmem_arbiter_if.slave).
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;
  logic              pick_we;

  // Contention goes to ptr; a lone request wins outright.
  always_comb begin
    pick = 1'b0;
    unique case (1'b1)
      bus.req0 && bus.req1: pick = ptr_q;
      !bus.req0 && bus.req1: pick = 1'b1;
      default: pick = 1'b0;
    endcase
    pick_we = pick ? bus.we1 : bus.we0;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d   = pick;
          we_d    = pick_we;
          addr_d  = pick ? bus.addr1 : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          cnt_d   = CNT_INIT;
          rd_d    = ~pick_we;
          wr_d    = pick_we;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q) rdata1_d = bus.mem_rdata;
            else       rdata0_d = bus.mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
        ptr_d   = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_rd    = rd_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: u0 runs MEM_LAT=2, u1 runs MEM_LAT=1.
// Stimulus pushes expected accesses; a negedge monitor pops on every ack.
module tb_dmem_arbiter;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   nvec = 0;
  int   nmis = 0;

  exp_t q0[$];
  exp_t q1[$];

  int          scnt[2] = '{0, 0};
  logic [31:0] saddr[2];
  logic [31:0] swd[2];
  bit          swe[2];
  bit          sst[2];
  logic [31:0] erd0[2] = '{32'h0, 32'h0};
  logic [31:0] erd1[2] = '{32'h0, 32'h0};

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h10:  memf = 32'hDEADBEEF;
      32'h20:  memf = 32'hA5A5A5A5;
      32'h30:  memf = 32'hCAFEF00D;
      32'h40:  memf = 32'h0BADC0DE;
      32'h50:  memf = 32'h11112222;
      32'h60:  memf = 32'h33334444;
      default: memf = a ^ 32'h5A5A0000;
    endcase
  endfunction

  assign b0.mem_rdata = memf(b0.mem_addr);
  assign b1.mem_rdata = memf(b1.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", nm, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit p, input logic r,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] wd);
    if (d == 0) begin
      if (!p) begin
        b0.req0 = r; b0.we0 = w; b0.addr0 = a; b0.wdata0 = wd;
      end else begin
        b0.req1 = r; b0.we1 = w; b0.addr1 = a; b0.wdata1 = wd;
      end
    end else begin
      if (!p) begin
        b1.req0 = r; b1.we0 = w; b1.addr0 = a; b1.wdata0 = wd;
      end else begin
        b1.req1 = r; b1.we1 = w; b1.addr1 = a; b1.wdata1 = wd;
      end
    end
  endtask

  task automatic set_req(input int d, input bit p, input logic r);
    if (d == 0) begin
      if (!p) b0.req0 = r;
      else    b0.req1 = r;
    end else begin
      if (!p) b1.req0 = r;
      else    b1.req1 = r;
    end
  endtask

  task automatic push(input int d, input bit p, input bit w,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rx, input int c);
    exp_t e;
    e.port = p; e.we = w; e.addr = a;
    e.wdata = wd; e.rdata = rx; e.cyc = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic single(input int d, input bit p, input bit w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rx);
    int lat = (d == 0) ? 2 : 1;
    int c = cyc;
    drive(d, p, 1'b1, w, a, wd);
    push(d, p, w, a, wd, rx, c + lat + 1);
    tick(lat + 1);
    set_req(d, p, 1'b0);
    tick(1);
  endtask

  task automatic mon(input int d, input logic a0, input logic a1,
                     input logic [31:0] r0, input logic [31:0] r1,
                     input logic rd, input logic wr,
                     input logic [31:0] ad, input logic [31:0] wd);
    exp_t e;
    bit   have;
    int   lat = (d == 0) ? 2 : 1;
    if (!rst) begin
      scnt[d] = 0;
      erd0[d] = '0;
      erd1[d] = '0;
      return;
    end
    if (rd || wr) begin
      if (scnt[d] == 0) begin
        saddr[d] = ad; swd[d] = wd; swe[d] = wr; sst[d] = 1'b1;
      end else if (ad !== saddr[d] || wd !== swd[d]) begin
        sst[d] = 1'b0;
      end
      scnt[d]++;
    end
    if (a0 || a1) begin
      chk($sformatf("d%0d_ack_both", d), 32'(a0 & a1), 32'h0);
      have = 1'b0;
      if (d == 0 && q0.size() > 0) begin
        e = q0.pop_front(); have = 1'b1;
      end else if (d == 1 && q1.size() > 0) begin
        e = q1.pop_front(); have = 1'b1;
      end
      nvec++;
      if (!have) begin
        nmis++;
        $display("FAIL d%0d_unexpected_ack: ack0=%0b ack1=%0b cyc %0d, none queued",
                 d, a0, a1, cyc);
      end else begin
        chk($sformatf("d%0d_port", d), 32'(a1), 32'(e.port));
        chk($sformatf("d%0d_ack_cyc", d), 32'(cyc), 32'(e.cyc));
        chk($sformatf("d%0d_strobe_len", d), 32'(scnt[d]), 32'(lat));
        chk($sformatf("d%0d_strobe_addr", d), saddr[d], e.addr);
        chk($sformatf("d%0d_strobe_we", d), 32'(swe[d]), 32'(e.we));
        chk($sformatf("d%0d_strobe_stable", d), 32'(sst[d]), 32'h1);
        if (e.we)
          chk($sformatf("d%0d_strobe_wdata", d), swd[d], e.wdata);
        else if (e.port)
          erd1[d] = e.rdata;
        else
          erd0[d] = e.rdata;
        chk($sformatf("d%0d_rdata0", d), r0, erd0[d]);
        chk($sformatf("d%0d_rdata1", d), r1, erd1[d]);
      end
      scnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, b0.ack0, b0.ack1, b0.rdata0, b0.rdata1,
        b0.mem_rd, b0.mem_wr, b0.mem_addr, b0.mem_wdata);
    mon(1, b1.ack0, b1.ack1, b1.rdata0, b1.rdata1,
        b1.mem_rd, b1.mem_wr, b1.mem_addr, b1.mem_wdata);
  end

  initial begin
    int c;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    tick(2);

    // reset state
    chk("rst_mem_rd", 32'(b0.mem_rd), 0);
    chk("rst_mem_wr", 32'(b0.mem_wr), 0);
    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_ack", 32'({b0.ack1, b0.ack0}), 0);
    chk("rst_rdata0", b0.rdata0, 0);
    chk("rst_rdata1", b0.rdata1, 0);
    chk("rst_mem_addr", b0.mem_addr, 0);
    chk("rst_mem_wdata", b0.mem_wdata, 0);
    rst = 1'b1;
    tick(1);

    // lone read, lone write, mixed traffic
    single(0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF);
    single(0, 1, 1, 32'h20, 32'h12345678, 32'h0);
    single(0, 1, 0, 32'h30, 32'h0, 32'hCAFEF00D);
    single(0, 0, 1, 32'h40, 32'h0F0F0F0F, 32'h0);

    // both requesting from reset, held: 0,1,0,1 every 4 cycles
    rst = 1'b0;
    tick(1);
    drive(0, 0, 1, 0, 32'h50, 32'h0);
    drive(0, 1, 1, 1, 32'h24, 32'h9ABCDEF0);
    rst = 1'b1;
    c = cyc;
    push(0, 0, 0, 32'h50, 32'h0, 32'h11112222, c + 3);
    push(0, 1, 1, 32'h24, 32'h9ABCDEF0, 32'h0, c + 7);
    push(0, 0, 0, 32'h50, 32'h0, 32'h11112222, c + 11);
    push(0, 1, 1, 32'h24, 32'h9ABCDEF0, 32'h0, c + 15);
    tick(15);
    set_req(0, 0, 0);
    set_req(0, 1, 0);
    tick(1);

    // req1 arrives during port 0 access
    c = cyc;
    drive(0, 0, 1, 0, 32'h10, 32'h0);
    push(0, 0, 0, 32'h10, 32'h0, 32'hDEADBEEF, c + 3);
    tick(1);
    drive(0, 1, 1, 0, 32'h30, 32'h0);
    push(0, 1, 0, 32'h30, 32'h0, 32'hCAFEF00D, c + 7);
    tick(2);
    set_req(0, 0, 0);
    chk("t4_addr_done", b0.mem_addr, 32'h10);
    tick(1);
    chk("t4_addr_idle", b0.mem_addr, 32'h10);
    tick(1);
    chk("t4_addr_grant", b0.mem_addr, 32'h30);
    tick(2);
    set_req(0, 1, 0);
    tick(1);

    // reset in the 2nd strobe cycle of a port 1 access (ptr is 1 here)
    single(0, 0, 0, 32'h40, 32'h0, 32'h0BADC0DE);
    drive(0, 1, 1, 0, 32'h50, 32'h0);
    tick(2);
    chk("t5_pre_rd", 32'(b0.mem_rd), 1);
    rst = 1'b0;
    #1;
    chk("t5_rd", 32'(b0.mem_rd), 0);
    chk("t5_wr", 32'(b0.mem_wr), 0);
    chk("t5_busy", 32'(b0.busy), 0);
    chk("t5_rdata0", b0.rdata0, 0);
    tick(1);
    drive(0, 0, 1, 0, 32'h20, 32'h0);
    rst = 1'b1;
    c = cyc;
    push(0, 0, 0, 32'h20, 32'h0, 32'hA5A5A5A5, c + 3);
    push(0, 1, 0, 32'h50, 32'h0, 32'h11112222, c + 7);
    tick(3);
    set_req(0, 0, 0);
    tick(4);
    set_req(0, 1, 0);
    tick(1);

    // MEM_LAT=1 with addr0 changed mid-access
    c = cyc;
    drive(1, 0, 1, 0, 32'h60, 32'h0);
    push(1, 0, 0, 32'h60, 32'h0, 32'h33334444, c + 2);
    tick(1);
    b1.addr0 = 32'h10;
    tick(1);
    set_req(1, 0, 0);
    chk("t6_addr_hold", b1.mem_addr, 32'h60);
    tick(1);
    single(1, 1, 1, 32'h44, 32'hFEEDFACE, 32'h0);
    single(1, 1, 0, 32'h30, 32'h0, 32'hCAFEF00D);

    for (int i = 0; i < 30; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      tick(1);
    end
    chk("sb_drain", 32'(q0.size() + q1.size()), 0);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
